// File: rtl/cc_reorder_unit_p.sv
// rtl/cc_reorder_unit_p.sv - read-data reorder unit merging buffered hit lines with streamed miss lines
//
// cc_reorder_unit_p ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_rdata_i/rlast_i/rvalid_i, mem_rready_o   memory R channel (miss data source)
//   flag_wren_i, flag_wdata_i, flag_afull_o       per-request {hit, start_ofs} flag queue
//   hit_wren_i, hit_wdata_i, hit_afull_o          full-line hit data queue
//   inct_rdata_o/rlast_o/rvalid_o, inct_rready_i  interconnect R channel (ordered output)
//   err_o                                         sticky protocol error
//
// cc_reorder_fifo ports:
//   wr_en/wr_data push, rd_en pop, rd_data head, empty, afull, overflow (push while full)

module cc_reorder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AFULL = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         afull,
    output logic         overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign afull    = (count >= CNT_W'(AFULL));
    // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
    assign overflow = wr_en & full;
    assign do_wr    = wr_en & ~full;
    assign do_rd    = rd_en & ~empty;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

module cc_reorder_unit_p #(
    parameter int DATA_W     = 64,
    parameter int BEATS      = 8,
    parameter int FLAG_DEPTH = 4,
    parameter int FLAG_AFULL = 3,
    parameter int HIT_DEPTH  = 2,
    parameter int HIT_AFULL  = 1,
    parameter int OFS_W      = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic                    mem_rlast_i,
    input  logic                    mem_rvalid_i,
    output logic                    mem_rready_o,
    input  logic                    flag_wren_i,
    input  logic [OFS_W:0]          flag_wdata_i,
    output logic                    flag_afull_o,
    input  logic                    hit_wren_i,
    input  logic [DATA_W*BEATS-1:0] hit_wdata_i,
    output logic                    hit_afull_o,
    output logic [DATA_W-1:0]       inct_rdata_o,
    output logic                    inct_rlast_o,
    output logic                    inct_rvalid_o,
    input  logic                    inct_rready_i,
    output logic                    err_o
);
    typedef enum logic [1:0] {IDLE, MISS, HIT} state_t;

    state_t                  state;
    logic [OFS_W-1:0]        beat;
    logic [OFS_W-1:0]        cur_ofs;

    logic [OFS_W:0]          flag_head;
    logic                    flag_empty;
    logic                    flag_ovf;
    logic                    flag_pop;
    logic [DATA_W*BEATS-1:0] hit_head;
    logic                    hit_empty;
    logic                    hit_ovf;
    logic                    hit_pop;

    logic                    in_miss;
    logic                    in_hit;
    logic                    last_beat;
    logic                    hs;
    logic [OFS_W-1:0]        word_idx;
    logic                    rlast_err;

    assign in_miss   = (state == MISS);
    assign in_hit    = (state == HIT);
    assign last_beat = (beat == OFS_W'(BEATS - 1));
    // Critical-word-first: beat 0 of a hit line is the requested start word.
    assign word_idx  = cur_ofs + beat;

    always_comb begin
        inct_rvalid_o = 1'b0;
        inct_rdata_o  = '0;
        if (in_miss) begin
            inct_rvalid_o = mem_rvalid_i;
            inct_rdata_o  = mem_rdata_i;
        end else if (in_hit) begin
            inct_rvalid_o = ~hit_empty;
            inct_rdata_o  = hit_head[word_idx*DATA_W +: DATA_W];
        end
    end

    assign mem_rready_o = in_miss & inct_rready_i;
    assign inct_rlast_o = inct_rvalid_o & last_beat;
    assign hs           = inct_rvalid_o & inct_rready_i;
    // Burst length is ours; memory rlast is only checked against it.
    assign rlast_err    = in_miss & hs & (mem_rlast_i != last_beat);
    // Popping on the last handshake lets the next request start with no bubble.
    assign flag_pop     = ~flag_empty & ((state == IDLE) | (hs & last_beat));
    assign hit_pop      = in_hit & hs & last_beat;

    cc_reorder_fifo #(.W(OFS_W + 1), .DEPTH(FLAG_DEPTH), .AFULL(FLAG_AFULL)) u_flag_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (flag_wren_i),
        .wr_data  (flag_wdata_i),
        .rd_en    (flag_pop),
        .rd_data  (flag_head),
        .empty    (flag_empty),
        .afull    (flag_afull_o),
        .overflow (flag_ovf)
    );

    cc_reorder_fifo #(.W(DATA_W * BEATS), .DEPTH(HIT_DEPTH), .AFULL(HIT_AFULL)) u_hit_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (hit_wren_i),
        .wr_data  (hit_wdata_i),
        .rd_en    (hit_pop),
        .rd_data  (hit_head),
        .empty    (hit_empty),
        .afull    (hit_afull_o),
        .overflow (hit_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            cur_ofs <= '0;
            err_o   <= 1'b0;
        end else begin
            if (flag_ovf || hit_ovf || rlast_err) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (flag_pop) begin
                        state   <= flag_head[OFS_W] ? HIT : MISS;
                        cur_ofs <= flag_head[OFS_W-1:0];
                        beat    <= '0;
                    end
                end
                default: begin
                    if (hs) begin
                        beat <= beat + OFS_W'(1);
                        if (last_beat) begin
                            if (flag_pop) begin
                                state   <= flag_head[OFS_W] ? HIT : MISS;
                                cur_ofs <= flag_head[OFS_W-1:0];
                                beat    <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule
